// File: rtl/seq_stream_ctrl_pkg.sv
// Shared types and default constants for the sequence-detector stream controller.
// The state encodings are fixed so that debug probes read the same values across builds.
package seq_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_TICK_DIV = 25_000_000;
  localparam int DEF_PAT_LEN  = 16;
  localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/seq_stream_ctrl_tick_gen.sv
// Bit-period timer: counts 0..TICK_DIV-1 while enabled and flags the terminal count.
// Dropping en clears the count, so every run starts on a full period.
module seq_tick_gen
  import seq_stream_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset || !en) begin
      cnt_q <= '0;
    end else if (cnt_q == TERM) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = en && (cnt_q == TERM);

endmodule

// File: rtl/seq_stream_ctrl.sv
// Stream controller: serialises a stored pattern MSB-first, one bit per TICK_DIV cycles,
// and counts rising edges of the detector output while a pass is in flight.
module seq_stream_ctrl
  import seq_stream_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int PAT_LEN  = DEF_PAT_LEN,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic               pattern_load,
  input  logic [PAT_LEN-1:0] pattern_in,
  input  logic               detected,
  output logic               seq_bit,
  output logic               seq_valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   det_count
);

  localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);

  state_t             state_q, state_d;
  logic [PAT_LEN-1:0] pattern_q;
  logic [PAT_LEN-1:0] shift_q;
  logic [IDX_W-1:0]   bit_idx_q;
  logic               seq_valid_q;
  logic               det_p1;
  logic [CNT_W-1:0]   cnt_q;

  logic tick;
  logic in_run;
  logic start_ok;
  logic last_bit;
  logic abort;
  logic adv;
  logic wrap;
  logic pass_end;
  logic det_edge;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  seq_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (in_run),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !stop) state_d = ST_RUN;
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick && last_bit && !loop_en) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_run   = (state_q == ST_RUN);
    busy     = in_run;
    done     = (state_q == ST_DONE);
    last_bit = (bit_idx_q == LAST_IDX);
    start_ok = (state_q == ST_IDLE) && start && !stop;
    abort    = in_run && stop;
    adv      = in_run && !stop && tick;
    wrap     = adv && last_bit && loop_en;
    pass_end = adv && last_bit && !loop_en;
    det_edge = detected && !det_p1 && (in_run || done);
  end

  // Serialiser: the shift register MSB is the line; it is zeroed whenever RUN is left.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pattern_q   <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      seq_valid_q <= 1'b0;
    end else begin
      seq_valid_q <= 1'b0;
      if ((state_q == ST_IDLE) && pattern_load) begin
        pattern_q <= pattern_in;
      end
      if (start_ok) begin
        shift_q     <= pattern_load ? pattern_in : pattern_q;
        bit_idx_q   <= '0;
        seq_valid_q <= 1'b1;
      end else if (abort || pass_end) begin
        shift_q   <= '0;
        bit_idx_q <= '0;
      end else if (wrap) begin
        shift_q     <= pattern_q;
        bit_idx_q   <= '0;
        seq_valid_q <= 1'b1;
      end else if (adv) begin
        shift_q     <= {shift_q[PAT_LEN-2:0], 1'b0};
        bit_idx_q   <= bit_idx_q + IDX_W'(1);
        seq_valid_q <= 1'b1;
      end
    end
  end

  // Detection counter: one-cycle history for edge detect, saturating increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      det_p1 <= 1'b0;
      cnt_q  <= '0;
    end else begin
      det_p1 <= detected;
      if (start_ok) begin
        cnt_q <= '0;
      end else if (det_edge) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end
  end

  assign seq_bit   = shift_q[PAT_LEN-1];
  assign seq_valid = seq_valid_q;
  assign det_count = cnt_q;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Bench for seq_stream_ctrl: directed stimulus queues expected stream bits,
// a negedge monitor pops and compares them on every seq_valid strobe.
module tb_seq_stream_ctrl;

  localparam int TICK_DIV = 4;
  localparam int PAT_LEN  = 8;
  localparam int CNT_W    = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               loop_en = 1'b0;
  logic               pattern_load = 1'b0;
  logic [PAT_LEN-1:0] pattern_in = '0;
  logic               detected = 1'b0;
  logic               seq_bit;
  logic               seq_valid;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   det_count;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int exp_done = 0;
  int since = 0;
  bit run_prev = 1'b0;
  bit exp_q[$];

  seq_stream_ctrl #(
    .TICK_DIV (TICK_DIV),
    .PAT_LEN  (PAT_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .pattern_load (pattern_load),
    .pattern_in   (pattern_in),
    .detected     (detected),
    .seq_bit      (seq_bit),
    .seq_valid    (seq_valid),
    .busy         (busy),
    .done         (done),
    .det_count    (det_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_pattern(input logic [PAT_LEN-1:0] p);
    for (int i = PAT_LEN - 1; i >= 0; i--) exp_q.push_back(p[i]);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      step(1);
    end
  endtask

  // Monitor: stream bits in order, full bit period between strobes, done pulse tally.
  always @(negedge clk) begin
    if (seq_valid === 1'b1) begin
      check("valid_in_run", busy, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        check("seq_bit", seq_bit, exp_q.pop_front());
      end
      if (run_prev) check("bit_hold", since, TICK_DIV);
      since = 1;
    end else if (busy === 1'b1) begin
      since++;
    end
    run_prev = (busy === 1'b1);
    if (done === 1'b1) done_seen++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;

    step(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_seq_bit", seq_bit, 0);
    check("rst_seq_valid", seq_valid, 0);
    check("rst_det_count", det_count, 0);
    reset = 1'b1;
    step(1);

    // 1: basic pass of 8'b1011_0010
    pattern_in = 8'hB2; pattern_load = 1'b1; step(1); pattern_load = 1'b0;
    push_pattern(8'hB2);
    start = 1'b1; step(1); start = 1'b0; exp_done++;
    wait_idle(n);
    check("t1_busy_len", n, 32);
    check("t1_done", done, 1);
    step(1);
    check("t1_done_once", done, 0);
    check("t1_idle", busy, 0);
    check("t1_queue", exp_q.size(), 0);
    check("t1_done_cnt", done_seen, exp_done);

    // 2: looping A5, then drop loop_en in the second pass
    pattern_in = 8'hA5; pattern_load = 1'b1; step(1); pattern_load = 1'b0;
    loop_en = 1'b1;
    push_pattern(8'hA5); push_pattern(8'hA5);
    start = 1'b1; step(1); start = 1'b0;
    step(40);
    check("t2_busy_loop", busy, 1);
    check("t2_no_done", done_seen, exp_done);
    loop_en = 1'b0; exp_done++;
    wait_idle(n);
    check("t2_tail_len", n, 24);
    check("t2_done", done, 1);
    step(1);
    check("t2_queue", exp_q.size(), 0);
    check("t2_done_cnt", done_seen, exp_done);

    // 3: stop at cycle 10 of a pass
    push_pattern(8'hA5);
    start = 1'b1; step(1); start = 1'b0;
    step(1); detected = 1'b1; step(1); detected = 1'b0;
    step(7);
    stop = 1'b1; step(1);
    check("t3_busy", busy, 0);
    check("t3_seq_bit", seq_bit, 0);
    check("t3_done", done, 0);
    check("t3_det_held", det_count, 1);
    check("t3_left", exp_q.size(), 5);
    exp_q.delete();
    start = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    check("t3_start_blocked", busy, 0);
    step(3);
    check("t3_det_still", det_count, 1);
    check("t3_done_cnt", done_seen, exp_done);

    // 4: ten 3-cycle detections saturate a 3-bit counter
    loop_en = 1'b1;
    push_pattern(8'hA5); push_pattern(8'hA5);
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      detected = 1'b1; step(3); detected = 1'b0; step(2);
      if (i == 2) check("t4_partial", det_count, 3);
    end
    loop_en = 1'b0; exp_done++;
    wait_idle(n);
    check("t4_tail_len", n, 14);
    check("t4_saturated", det_count, 7);
    check("t4_done", done, 1);
    step(1);
    check("t4_queue", exp_q.size(), 0);

    // 5: load and start while busy are ignored
    push_pattern(8'hA5);
    start = 1'b1; step(1); start = 1'b0;
    check("t5_cleared", det_count, 0);
    step(5);
    pattern_in = 8'hFF; pattern_load = 1'b1; start = 1'b1; step(1);
    pattern_load = 1'b0; start = 1'b0; exp_done++;
    wait_idle(n);
    check("t5_busy_rest", n, 26);
    check("t5_done", done, 1);
    step(1);
    check("t5_queue", exp_q.size(), 0);
    push_pattern(8'hA5);
    start = 1'b1; step(1); start = 1'b0; exp_done++;
    wait_idle(n);
    check("t5_old_pat_len", n, 32);
    step(1);
    check("t5_old_pat_queue", exp_q.size(), 0);
    check("t5_done_cnt", done_seen, exp_done);

    // 6: reset mid-run, then start with a same-cycle load
    push_pattern(8'hA5);
    start = 1'b1; step(1); start = 1'b0;
    step(1); detected = 1'b1; step(1); detected = 1'b0;
    step(7);
    check("t6_det_pre", det_count, 1);
    reset = 1'b0; step(1);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_seq_bit", seq_bit, 0);
    check("t6_seq_valid", seq_valid, 0);
    check("t6_det_count", det_count, 0);
    reset = 1'b1;
    check("t6_left", exp_q.size(), 5);
    exp_q.delete();
    push_pattern(8'h3C);
    pattern_in = 8'h3C; pattern_load = 1'b1; start = 1'b1; step(1);
    pattern_load = 1'b0; start = 1'b0; exp_done++;
    wait_idle(n);
    check("t6_busy_len", n, 32);
    check("t6_done", done, 1);
    step(1);
    check("t6_queue", exp_q.size(), 0);
    check("t6_done_cnt", done_seen, exp_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
